// File: rtl/fifo_cmd_writer.sv
// fifo_cmd_writer: paced byte writer for an async command FIFO (define FIFOWR_WRCOUNT_EN to add the wr_count port)
module fifo_cmd_writer #(
  parameter int unsigned SETUP_TICKS   = 2,
  parameter int unsigned PULSE_TICKS   = 4,
  parameter int unsigned RECOVER_TICKS = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        fifo_nff_in,
  output logic [7:0]  fifo_data,
  output logic        fifo_nwr,
  output logic        fifo_full,
`ifdef FIFOWR_WRCOUNT_EN
  output logic [15:0] wr_count,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_TICKS - 1);
  localparam logic [7:0] PULSE_LD   = 8'(PULSE_TICKS - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVER_TICKS - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       nwr_q, nwr_d;
  logic       ready_q, ready_d;
  logic       nff_meta_q, nff_sync_q;
  assign in_ready  = ready_q;
  assign fifo_data = data_q;
  assign fifo_nwr  = nwr_q;
  assign fifo_full = ~nff_sync_q;
  assign busy      = state_q != IDLE;
  // Synchronize the async full flag; resets to 0 so the FIFO is presumed full
  always_ff @(posedge clk) begin
    if (!nrst) begin
      nff_meta_q <= 1'b0;
      nff_sync_q <= 1'b0;
    end else begin
      nff_meta_q <= fifo_nff_in;
      nff_sync_q <= nff_meta_q;
    end
  end
  // Write sequencing: setup (stalls while full), strobe, recovery gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    nwr_d   = nwr_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          data_d  = in_data;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
          ready_d = 1'b0;
        end else ready_d = 1'b1;
      end
      SETUP: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else if (nff_sync_q) begin
          nwr_d   = 1'b0;
          cnt_d   = PULSE_LD;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else begin
          nwr_d   = 1'b1;
          cnt_d   = RECOVER_LD;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset mid-write raises the strobe and drops the byte
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      data_q  <= 8'h00;
      nwr_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      nwr_q   <= nwr_d;
      ready_q <= ready_d;
    end
  end
`ifdef FIFOWR_WRCOUNT_EN
  logic [15:0] wr_count_q;
  logic        wr_done;
  assign wr_done  = state_q == STROBE && cnt_q == 8'd0;
  assign wr_count = wr_count_q;
  // Count strobes that complete normally; reset-truncated ones never reach wr_done
  always_ff @(posedge clk) begin
    if (!nrst) wr_count_q <= 16'd0;
    else if (wr_done) wr_count_q <= wr_count_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_cmd_writer.sv
// tb_fifo_cmd_writer: randomized and directed checks against an edge-numbered reference model
module tb_fifo_cmd_writer;
  localparam int SETUP = 2, PULSE = 4, RECOVER = 4;
  logic       clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, fifo_nff_in = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, fifo_nwr, fifo_full, busy;
  logic [7:0] fifo_data;
`ifdef FIFOWR_WRCOUNT_EN
  logic [15:0] wr_count;
`endif
  int n_tests = 0, n_fail = 0, edge_n = 0;
  logic       m_ready = 1'b0, m_busy = 1'b0, m_nwr = 1'b1, m_meta = 1'b0, m_sync = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [15:0] m_cnt = 16'd0;
  int acc_e = 0, fall_e = -1;
  int acc_list[$];
  int low_cycles;

  fifo_cmd_writer #(.SETUP_TICKS(SETUP), .PULSE_TICKS(PULSE), .RECOVER_TICKS(RECOVER)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_nff_in(fifo_nff_in), .fifo_data(fifo_data), .fifo_nwr(fifo_nwr), .fifo_full(fifo_full),
`ifdef FIFOWR_WRCOUNT_EN
    .wr_count(wr_count),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
    end
  endtask

  // Reference: writes are placed on absolute edge numbers relative to the accept/fall edges
  task automatic model_edge();
    edge_n++;
    if (!nrst) begin
      m_ready = 0; m_busy = 0; m_nwr = 1; m_data = 0; m_meta = 0; m_sync = 0; m_cnt = 0; fall_e = -1;
    end else begin
      if (!m_busy) begin
        if (in_valid && m_ready) begin
          m_data = in_data; m_busy = 1; m_ready = 0; acc_e = edge_n; fall_e = -1;
        end else m_ready = 1;
      end else if (fall_e < 0) begin
        if (edge_n >= acc_e + SETUP && m_sync) begin fall_e = edge_n; m_nwr = 0; end
      end else if (edge_n == fall_e + PULSE) begin
        m_nwr = 1; m_cnt++;
      end else if (edge_n == fall_e + PULSE + RECOVER) begin
        m_busy = 0; m_ready = 1;
      end
      m_sync = m_meta;
      m_meta = fifo_nff_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("fifo_nwr", fifo_nwr, m_nwr);
    chk("fifo_data", fifo_data, m_data);
    chk("fifo_full", fifo_full, !m_sync);
`ifdef FIFOWR_WRCOUNT_EN
    chk("wr_count", wr_count, m_cnt);
`endif
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !in_ready; i++) step();
    chk("idle_reached", in_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) step();
    chk("rst_nwr", fifo_nwr, 1);
    chk("rst_full", fifo_full, 1);
    nrst = 1;
    step();
    chk("ready_after_rst", in_ready, 1);
    step();
    chk("full_clear_2", fifo_full, 0);

    in_valid = 1; in_data = 8'hA5;
    step();
    in_valid = 0; in_data = 8'h00;
    chk("a5_data", fifo_data, 8'hA5);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("a5_nwr", fifo_nwr, (k >= 2 && k <= 5) ? 0 : 1);
      chk("a5_ready", in_ready, k == 10);
    end

    fifo_nff_in = 0;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1; in_data = 8'h3C;
    step();
    in_valid = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("stall_nwr", fifo_nwr, 1);
      chk("stall_busy", busy, 1);
      chk("stall_data", fifo_data, 8'h3C);
    end
    fifo_nff_in = 1;
    step();
    chk("rel_r0", fifo_nwr, 1);
    step();
    chk("rel_r1", fifo_nwr, 1);
    step();
    chk("rel_r2", fifo_nwr, 0);
    wait_idle();

    in_valid = 1; in_data = 8'h01; low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_valid && in_ready) begin
        acc_list.push_back(edge_n + 1);
        step();
        if (acc_list.size() == 3) in_valid = 0;
        else in_data = in_data + 8'd1;
      end else step();
      if (!fifo_nwr) begin
        low_cycles++;
        chk("b2b_data", fifo_data, 8'(acc_list.size()));
      end
    end
    chk("b2b_accepts", acc_list.size(), 3);
    if (acc_list.size() == 3) begin
      chk("b2b_gap1", acc_list[1] - acc_list[0], 11);
      chk("b2b_gap2", acc_list[2] - acc_list[1], 11);
    end
    chk("b2b_low", low_cycles, 12);
    wait_idle();

    in_valid = 1; in_data = 8'h77;
    step();
    in_valid = 0;
    for (int i = 0; i < 10 && fifo_nwr; i++) step();
    chk("mid_fall", fifo_nwr, 0);
    step();
    nrst = 0;
    step();
    chk("mid_nwr", fifo_nwr, 1);
    chk("mid_data", fifo_data, 0);
`ifdef FIFOWR_WRCOUNT_EN
    chk("mid_cnt", wr_count, 0);
`endif
    nrst = 1;
    step();
    step();
    step();

`ifdef FIFOWR_WRCOUNT_EN
    dut.wr_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    for (int w = 0; w < 2; w++) begin
      wait_idle();
      in_valid = 1; in_data = 8'(w);
      step();
      in_valid = 0;
    end
    wait_idle();
    chk("wrap", wr_count, 16'h0000);
`endif

    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom % 2);
      in_data = 8'($urandom);
      if ($urandom % 16 == 0) fifo_nff_in = ~fifo_nff_in;
      nrst = ($urandom % 300) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
